// File: rtl/apb_master_if.sv
// Signal bundle between a CPU-side requester, the APB master and up to four APB slaves.
// The master modport is the bridge's view; the slave modport is the view of the CPU and slave side.
interface apb_master_if;
    // CPU request side
    logic        transfer;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    // APB side
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic [3:0]  PSEL;
    logic [31:0] PRDATA0;
    logic [31:0] PRDATA1;
    logic [31:0] PRDATA2;
    logic [31:0] PRDATA3;
    logic        PREADY0;
    logic        PREADY1;
    logic        PREADY2;
    logic        PREADY3;

    modport master (
        input  transfer, addr, wdata, write,
        output rdata, ready, err,
        output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        input  PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        input  PREADY0, PREADY1, PREADY2, PREADY3
    );

    modport slave (
        output transfer, addr, wdata, write,
        input  rdata, ready, err,
        input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        output PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        output PREADY0, PREADY1, PREADY2, PREADY3
    );
endinterface

// File: rtl/apb_master.sv
// CPU-to-APB bridge: decodes four 4 KiB slave windows at 0x1000_0000 and runs SETUP/ACCESS
// transfers with a wait-state timeout; unmapped addresses and timeouts complete with err=1.
module apb_master #(
    parameter int TIMEOUT = 16
) (
    input  logic         PCLK,
    input  logic         PRESETn,
    apb_master_if.master bus
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state_q, state_n;
    logic [31:0] paddr_q, paddr_n;
    logic [31:0] pwdata_q, pwdata_n;
    logic [31:0] rdata_q, rdata_n;
    logic        pwrite_q, pwrite_n;
    logic        penable_q, penable_n;
    logic [3:0]  psel_q, psel_n;
    logic [1:0]  sel_q, sel_n;
    logic [7:0]  cnt_q, cnt_n;
    logic        ready_q, ready_n;
    logic        err_q, err_n;

    logic        mapped;
    logic [1:0]  dec_idx;
    logic        sel_ready;
    logic [31:0] sel_rdata;

    // addr[31:12] in 0x10000..0x10003: upper 18 bits fixed, bits 13:12 pick the slave
    assign mapped  = (bus.addr[31:14] == 18'h04000);
    assign dec_idx = bus.addr[13:12];

    // Only the slave latched at SETUP is ever listened to
    always_comb begin
        case (sel_q)
            2'd0:    begin sel_ready = bus.PREADY0; sel_rdata = bus.PRDATA0; end
            2'd1:    begin sel_ready = bus.PREADY1; sel_rdata = bus.PRDATA1; end
            2'd2:    begin sel_ready = bus.PREADY2; sel_rdata = bus.PRDATA2; end
            default: begin sel_ready = bus.PREADY3; sel_rdata = bus.PRDATA3; end
        endcase
    end

    always_comb begin
        // NOTE: every next-value gets a default first so no path through the case infers a latch.
        state_n   = state_q;
        paddr_n   = paddr_q;
        pwdata_n  = pwdata_q;
        pwrite_n  = pwrite_q;
        psel_n    = psel_q;
        penable_n = penable_q;
        sel_n     = sel_q;
        cnt_n     = cnt_q;
        rdata_n   = rdata_q;
        ready_n   = 1'b0;
        err_n     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.transfer) begin
                    if (mapped) begin
                        paddr_n   = bus.addr;
                        pwdata_n  = bus.wdata;
                        pwrite_n  = bus.write;
                        sel_n     = dec_idx;
                        psel_n    = 4'(4'b0001 << dec_idx);
                        penable_n = 1'b0;
                        cnt_n     = 8'd0;
                        state_n   = SETUP;
                    end else begin
                        ready_n = 1'b1;
                        err_n   = 1'b1;
                        rdata_n = 32'd0;
                        state_n = DERR;
                    end
                end
            end
            SETUP: begin
                penable_n = 1'b1;
                state_n   = ACCESS;
            end
            ACCESS: begin
                if (sel_ready) begin
                    ready_n   = 1'b1;
                    if (!pwrite_q) rdata_n = sel_rdata;
                    psel_n    = 4'd0;
                    penable_n = 1'b0;
                    state_n   = IDLE;
                end else if (cnt_q == LAST_WAIT) begin
                    // This is the TIMEOUT-th wait cycle: give up on the slave
                    ready_n   = 1'b1;
                    err_n     = 1'b1;
                    rdata_n   = 32'd0;
                    psel_n    = 4'd0;
                    penable_n = 1'b0;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end
            DERR: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            paddr_q   <= 32'd0;
            pwdata_q  <= 32'd0;
            pwrite_q  <= 1'b0;
            psel_q    <= 4'd0;
            penable_q <= 1'b0;
            sel_q     <= 2'd0;
            cnt_q     <= 8'd0;
            rdata_q   <= 32'd0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            paddr_q   <= paddr_n;
            pwdata_q  <= pwdata_n;
            pwrite_q  <= pwrite_n;
            psel_q    <= psel_n;
            penable_q <= penable_n;
            sel_q     <= sel_n;
            cnt_q     <= cnt_n;
            rdata_q   <= rdata_n;
            ready_q   <= ready_n;
            err_q     <= err_n;
        end
    end

    assign bus.PADDR   = paddr_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PSEL    = psel_q;
    assign bus.PENABLE = penable_q;
    assign bus.rdata   = rdata_q;
    assign bus.ready   = ready_q;
    assign bus.err     = err_q;

endmodule
